dmem_port_arbiter: RTL and testbench

Shares one data-memory port between the memory stages of the two issue lanes (lane 1, lane 2) of the dual-issue pipeline. Same-cycle requests are serialised in program order: lower PC first. While serialising, the block raises a pipeline stall. Branch-kill inputs from hazard control drop younger requests that have not yet issued.

---
 rtl/dmem_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between the memory stages of the two
// issue lanes. Same-cycle requests are serialised in program order (lower PC first), and the
// pipeline is stalled while serialising. Branch kills drop requests that are not yet on the port.
// Optional build macro: DMEM_ARB_PERF_EN adds perf_conflict_cnt / perf_stall_cnt counters.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // Lane 1 memory stage
    input  logic                    req1,
    input  logic                    we1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]   wdata1,
    input  logic [DATA_WIDTH/8-1:0] be1,
    input  logic [ADDR_WIDTH-1:0]   pc1,
    input  logic                    kill1,
    // Lane 2 memory stage
    input  logic                    req2,
    input  logic                    we2,
    input  logic [ADDR_WIDTH-1:0]   addr2,
    input  logic [DATA_WIDTH-1:0]   wdata2,
    input  logic [DATA_WIDTH/8-1:0] be2,
    input  logic [ADDR_WIDTH-1:0]   pc2,
    input  logic                    kill2,
    // Load data back to the lanes and pipeline hold
    output logic [DATA_WIDTH-1:0]   rdata1,
    output logic [DATA_WIDTH-1:0]   rdata2,
    output logic                    mem_stall,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]             perf_conflict_cnt,
    output logic [31:0]             perf_stall_cnt,
`endif
    // Shared memory port
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    typedef enum logic [1:0] {StIdle, StFirst, StSecond} arbStateT;

    arbStateT              stateQ, stateD;
    logic                  firstLaneQ, firstLaneD;   // 0: lane 1 went first, 1: lane 2
    logic                  singleQ, singleD;         // FIRST serves a lone request
    logic                  pendKillQ, pendKillD;     // pending lane was killed during FIRST
    logic                  secIssuedQ, secIssuedD;   // second access already on the port
    logic [DATA_WIDTH-1:0] holdDataQ, holdDataD;

    logic                  e1, e2;
    logic                  lane2First;
    logic                  pendingKill;
    logic                  sel;                      // 1 selects lane 2 attributes
    logic                  reqC, stallC;
    logic [DATA_WIDTH-1:0] rdata1C, rdata2C;

    assign e1          = req1 & ~kill1;
    assign e2          = req2 & ~kill2;
    assign lane2First  = pc2 < pc1;
    // Kill of the lane that was not issued first
    assign pendingKill = firstLaneQ ? kill1 : kill2;

    assign mem_we    = sel ? we2    : we1;
    assign mem_addr  = sel ? addr2  : addr1;
    assign mem_wdata = sel ? wdata2 : wdata1;
    assign mem_be    = sel ? be2    : be1;

    // Reset forces the visible handshake and data outputs low immediately
    assign mem_req   = reqC & ~rst;
    assign mem_stall = stallC & ~rst;
    assign rdata1    = rst ? '0 : rdata1C;
    assign rdata2    = rst ? '0 : rdata2C;

    // Arbiter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= StIdle;
            firstLaneQ <= 1'b0;
            singleQ    <= 1'b0;
            pendKillQ  <= 1'b0;
            secIssuedQ <= 1'b0;
            holdDataQ  <= '0;
        end else begin
            stateQ     <= stateD;
            firstLaneQ <= firstLaneD;
            singleQ    <= singleD;
            pendKillQ  <= pendKillD;
            secIssuedQ <= secIssuedD;
            holdDataQ  <= holdDataD;
        end
    end

    // Next state, port request, stall and load-data steering
    always_comb begin
        stateD     = stateQ;
        firstLaneD = firstLaneQ;
        singleD    = singleQ;
        pendKillD  = pendKillQ;
        secIssuedD = secIssuedQ;
        holdDataD  = holdDataQ;
        sel        = 1'b0;
        reqC       = 1'b0;
        stallC     = 1'b0;
        rdata1C    = '0;
        rdata2C    = '0;

        unique case (stateQ)
            StIdle: begin
                if (e1 && e2) begin
                    sel        = lane2First;
                    reqC       = 1'b1;
                    stallC     = 1'b1;
                    firstLaneD = lane2First;
                    singleD    = 1'b0;
                    pendKillD  = 1'b0;
                    if (mem_ready) begin
                        holdDataD  = mem_rdata;
                        secIssuedD = 1'b0;
                        stateD     = StSecond;
                    end else begin
                        stateD = StFirst;
                    end
                end else if (e1 || e2) begin
                    sel  = e2;
                    reqC = 1'b1;
                    if (mem_ready) begin
                        // Zero-latency path: data straight through, no stall
                        if (e2) rdata2C = mem_rdata;
                        else    rdata1C = mem_rdata;
                    end else begin
                        stallC     = 1'b1;
                        firstLaneD = e2;
                        singleD    = 1'b1;
                        pendKillD  = 1'b0;
                        stateD     = StFirst;
                    end
                end
            end

            StFirst: begin
                sel    = firstLaneQ;
                reqC   = 1'b1;
                stallC = 1'b1;
                if (!singleQ) pendKillD = pendKillQ | pendingKill;
                if (mem_ready) begin
                    if (singleQ || pendKillQ || pendingKill) begin
                        // Nothing left to serve: release in this cycle
                        stallC = 1'b0;
                        if (firstLaneQ) rdata2C = mem_rdata;
                        else            rdata1C = mem_rdata;
                        pendKillD = 1'b0;
                        stateD    = StIdle;
                    end else begin
                        holdDataD  = mem_rdata;
                        secIssuedD = 1'b0;
                        stateD     = StSecond;
                    end
                end
            end

            StSecond: begin
                if (firstLaneQ) rdata2C = holdDataQ;
                else            rdata1C = holdDataQ;
                if (!secIssuedQ && pendingKill) begin
                    // Second access squashed before reaching the port
                    stateD = StIdle;
                end else begin
                    sel  = ~firstLaneQ;
                    reqC = 1'b1;
                    if (mem_ready) begin
                        if (firstLaneQ) rdata1C = mem_rdata;
                        else            rdata2C = mem_rdata;
                        secIssuedD = 1'b0;
                        stateD     = StIdle;
                    end else begin
                        stallC     = 1'b1;
                        secIssuedD = 1'b1;
                    end
                end
            end

            default: stateD = StIdle;
        endcase
    end

`ifdef DMEM_ARB_PERF_EN
    // Conflict and stall-cycle counters; both wrap at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_cnt <= 32'd0;
            perf_stall_cnt    <= 32'd0;
        end else begin
            if (stateQ == StIdle && e1 && e2) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            if (stallC)                       perf_stall_cnt    <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a table of single-cycle IDLE vectors plus
// hand-written multi-cycle sequences (ordering, wait states, kills, asynchronous reset).
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req1, we1, kill1, req2, we2, kill2;
    logic [31:0] addr1, wdata1, pc1, addr2, wdata2, pc2;
    logic [3:0]  be1, be2;
    logic [31:0] rdata1, rdata2;
    logic        mem_stall, mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perfConflictCnt, perfStallCnt;
`endif

    // Memory stimulus: either a small word memory or a directly driven value
    logic        useMem = 1'b0;
    logic [31:0] tbRdata = 32'h0;
    logic [31:0] memArr [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = useMem ? memArr[mem_addr[7:2]] : tbRdata;

    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready) memArr[mem_addr[7:2]] <= mem_wdata;
    end

    dmem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .be1       (be1),
        .pc1       (pc1),
        .kill1     (kill1),
        .req2      (req2),
        .we2       (we2),
        .addr2     (addr2),
        .wdata2    (wdata2),
        .be2       (be2),
        .pc2       (pc2),
        .kill2     (kill2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .mem_stall (mem_stall),
`ifdef DMEM_ARB_PERF_EN
        .perf_conflict_cnt (perfConflictCnt),
        .perf_stall_cnt    (perfStallCnt),
`endif
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        r1, k1, w1;
        logic [31:0] a1, d1, p1;
        logic [3:0]  b1;
        logic        r2, k2, w2;
        logic [31:0] a2, d2, p2;
        logic [3:0]  b2;
        logic        rdy;
        logic [31:0] mrd;
        logic        xReq, xStall, xWe;
        logic [31:0] xAddr, xWdata;
        logic [3:0]  xBe;
        logic [31:0] xRd1, xRd2;
    } vecT;

    vecT vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic setLane1(input logic r, input logic k, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] p, input logic [3:0] b);
        req1 = r; kill1 = k; we1 = w; addr1 = a; wdata1 = d; pc1 = p; be1 = b;
    endtask

    task automatic setLane2(input logic r, input logic k, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] p, input logic [3:0] b);
        req2 = r; kill2 = k; we2 = w; addr2 = a; wdata2 = d; pc2 = p; be2 = b;
    endtask

    task automatic clearLanes();
        setLane1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
        setLane2(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stallCycles;
        for (int i = 0; i < 64; i++) memArr[i] = 32'h0;
        clearLanes();
        mem_ready = 1'b0;

        // r1 k1 w1 a1 d1 p1 b1 | r2 k2 w2 a2 d2 p2 b2 | rdy mrd | req stall we addr wdata be rd1 rd2
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h100, 32'h11, 32'h10, 4'hF,
                     1'b0, 1'b0, 1'b0, 32'h200, 32'h22, 32'h14, 4'h3, 1'b1, 32'h5A5A,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h11, 32'h10, 4'hF,
                     1'b0, 1'b0, 1'b0, 32'h200, 32'h22, 32'h14, 4'h3, 1'b1, 32'hDEADBEEF,
                     1'b1, 1'b0, 1'b0, 32'h100, 32'h11, 4'hF, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h100, 32'h11, 32'h10, 4'hF,
                     1'b1, 1'b0, 1'b1, 32'h200, 32'h55, 32'h14, 4'h3, 1'b1, 32'h1234,
                     1'b1, 1'b0, 1'b1, 32'h200, 32'h55, 4'h3, 32'h0, 32'h1234};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h11, 32'h10, 4'hF,
                     1'b0, 1'b0, 1'b0, 32'h200, 32'h22, 32'h14, 4'h3, 1'b0, 32'h999,
                     1'b1, 1'b1, 1'b0, 32'h100, 32'h11, 4'hF, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'h40, 32'hAA, 32'h20, 4'hF,
                     1'b1, 1'b0, 1'b0, 32'h40, 32'h22, 32'h24, 4'h3, 1'b1, 32'h1,
                     1'b1, 1'b1, 1'b1, 32'h40, 32'hAA, 4'hF, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h40, 32'hAA, 32'h28, 4'hF,
                     1'b1, 1'b0, 1'b0, 32'h40, 32'h22, 32'h24, 4'h3, 1'b1, 32'h1,
                     1'b1, 1'b1, 1'b0, 32'h40, 32'h22, 4'h3, 32'h0, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'h40, 32'hAA, 32'h30, 4'hF,
                     1'b1, 1'b0, 1'b0, 32'h40, 32'h22, 32'h30, 4'h3, 1'b1, 32'h1,
                     1'b1, 1'b1, 1'b1, 32'h40, 32'hAA, 4'hF, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h11, 32'h10, 4'hF,
                     1'b1, 1'b1, 1'b0, 32'h200, 32'h22, 32'h14, 4'h3, 1'b1, 32'hCAFE,
                     1'b1, 1'b0, 1'b0, 32'h100, 32'h11, 4'hF, 32'hCAFE, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h11, 32'h10, 4'hF,
                     1'b1, 1'b1, 1'b0, 32'h200, 32'h22, 32'h14, 4'h3, 1'b1, 32'h77,
                     1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h11, 32'h10, 4'hF,
                     1'b1, 1'b0, 1'b0, 32'h200, 32'h22, 32'h14, 4'h3, 1'b0, 32'h77,
                     1'b1, 1'b1, 1'b0, 32'h200, 32'h22, 4'h3, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h11, 32'h80000000, 4'hF,
                     1'b1, 1'b0, 1'b0, 32'h200, 32'h22, 32'h4, 4'h3, 1'b1, 32'h77,
                     1'b1, 1'b1, 1'b0, 32'h200, 32'h22, 4'h3, 32'h0, 32'h0};

        // Reset state with idle inputs
        rst = 1'b1;
        tick();
        #3;
        chk("reset.mem_req", {31'h0, mem_req}, 32'h0);
        chk("reset.mem_stall", {31'h0, mem_stall}, 32'h0);
        chk("reset.rdata1", rdata1, 32'h0);
        chk("reset.rdata2", rdata2, 32'h0);
        rst = 1'b0;

        // Table: each vector from a freshly reset IDLE state
        for (int i = 0; i < 11; i++) begin
            tick();
            pulseReset();
            setLane1(vecs[i].r1, vecs[i].k1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].p1,
                     vecs[i].b1);
            setLane2(vecs[i].r2, vecs[i].k2, vecs[i].w2, vecs[i].a2, vecs[i].d2, vecs[i].p2,
                     vecs[i].b2);
            mem_ready = vecs[i].rdy;
            tbRdata   = vecs[i].mrd;
            #3;
            chk($sformatf("v%0d.mem_req", i), {31'h0, mem_req}, {31'h0, vecs[i].xReq});
            chk($sformatf("v%0d.mem_stall", i), {31'h0, mem_stall}, {31'h0, vecs[i].xStall});
            chk($sformatf("v%0d.rdata1", i), rdata1, vecs[i].xRd1);
            chk($sformatf("v%0d.rdata2", i), rdata2, vecs[i].xRd2);
            if (vecs[i].xReq) begin
                chk($sformatf("v%0d.mem_we", i), {31'h0, mem_we}, {31'h0, vecs[i].xWe});
                chk($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].xAddr);
                chk($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].xWdata);
                chk($sformatf("v%0d.mem_be", i), {28'h0, mem_be}, {28'h0, vecs[i].xBe});
            end
            clearLanes();
        end

        // Store then load to the same address, ready every cycle
        tick();
        pulseReset();
        useMem    = 1'b1;
        mem_ready = 1'b1;
        setLane1(1'b1, 1'b0, 1'b1, 32'h40, 32'hAA, 32'h20, 4'hF);
        setLane2(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h24, 4'hF);
        #3;
        chk("st_ld.c0.we", {31'h0, mem_we}, 32'h1);
        chk("st_ld.c0.stall", {31'h0, mem_stall}, 32'h1);
        tick();
        #3;
        chk("st_ld.c1.we", {31'h0, mem_we}, 32'h0);
        chk("st_ld.c1.stall", {31'h0, mem_stall}, 32'h0);
        chk("st_ld.c1.rdata2", rdata2, 32'hAA);
        // Reverse order: lane 2 load goes first and sees the old value
        tick();
        setLane1(1'b1, 1'b0, 1'b1, 32'h40, 32'hBB, 32'h28, 4'hF);
        setLane2(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h24, 4'hF);
        #3;
        chk("ld_st.c0.we", {31'h0, mem_we}, 32'h0);
        chk("ld_st.c0.stall", {31'h0, mem_stall}, 32'h1);
        tick();
        #3;
        chk("ld_st.c1.we", {31'h0, mem_we}, 32'h1);
        chk("ld_st.c1.wdata", mem_wdata, 32'hBB);
        chk("ld_st.c1.stall", {31'h0, mem_stall}, 32'h0);
        chk("ld_st.c1.rdata2", rdata2, 32'hAA);
        tick();
        setLane1(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h2C, 4'hF);
        setLane2(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0);
        #3;
        chk("ld_after.stall", {31'h0, mem_stall}, 32'h0);
        chk("ld_after.rdata1", rdata1, 32'hBB);
        useMem = 1'b0;
        clearLanes();

        // Two loads, three wait cycles each: seven stall cycles, stable attributes
        tick();
        pulseReset();
        setLane1(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h50, 4'hF);
        setLane2(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h54, 4'h3);
        stallCycles = 0;
        for (int c = 0; c < 8; c++) begin
            mem_ready = (c == 3 || c == 7);
            tbRdata   = (c == 3) ? 32'h11111111 : (c == 7) ? 32'h22222222 : (32'hBAD00000 | c);
            #3;
            chk($sformatf("wait.c%0d.req", c), {31'h0, mem_req}, 32'h1);
            chk($sformatf("wait.c%0d.addr", c), mem_addr, (c < 4) ? 32'h300 : 32'h304);
            chk($sformatf("wait.c%0d.be", c), {28'h0, mem_be}, (c < 4) ? 32'hF : 32'h3);
            chk($sformatf("wait.c%0d.stall", c), {31'h0, mem_stall}, (c < 7) ? 32'h1 : 32'h0);
            if (mem_stall) stallCycles++;
            if (c == 7) begin
                chk("wait.rdata1", rdata1, 32'h11111111);
                chk("wait.rdata2", rdata2, 32'h22222222);
            end
            tick();
        end
        chk("wait.stall_cycles", stallCycles, 32'd7);
        clearLanes();

        // Kill lane 2 while FIRST waits on lane 1
        pulseReset();
        setLane1(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h60, 4'hF);
        setLane2(1'b1, 1'b0, 1'b0, 32'h404, 32'h0, 32'h64, 4'hF);
        for (int c = 0; c < 3; c++) begin
            kill2     = (c >= 1);
            mem_ready = (c == 2);
            tbRdata   = (c == 2) ? 32'h77 : 32'hBAD;
            #3;
            chk($sformatf("kill.c%0d.no_lane2", c), {31'h0, mem_req && mem_addr == 32'h404},
                32'h0);
            chk($sformatf("kill.c%0d.stall", c), {31'h0, mem_stall}, (c < 2) ? 32'h1 : 32'h0);
            if (c == 2) begin
                chk("kill.rdata1", rdata1, 32'h77);
                chk("kill.rdata2", rdata2, 32'h0);
            end
            tick();
        end
        clearLanes();
        #3;
        chk("kill.after.req", {31'h0, mem_req}, 32'h0);
        chk("kill.after.stall", {31'h0, mem_stall}, 32'h0);

        // Kill of the pending lane on entry to SECOND
        tick();
        pulseReset();
        setLane1(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h60, 4'hF);
        setLane2(1'b1, 1'b0, 1'b0, 32'h404, 32'h0, 32'h64, 4'hF);
        mem_ready = 1'b1;
        tbRdata   = 32'h5151;
        #3;
        chk("kill2nd.c0.stall", {31'h0, mem_stall}, 32'h1);
        tick();
        kill2   = 1'b1;
        tbRdata = 32'h9999;
        #3;
        chk("kill2nd.c1.req", {31'h0, mem_req}, 32'h0);
        chk("kill2nd.c1.stall", {31'h0, mem_stall}, 32'h0);
        chk("kill2nd.c1.rdata1", rdata1, 32'h5151);
        chk("kill2nd.c1.rdata2", rdata2, 32'h0);
        tick();
        clearLanes();

        // Asynchronous reset in the middle of SECOND
        pulseReset();
        setLane1(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h70, 4'hF);
        setLane2(1'b1, 1'b0, 1'b0, 32'h504, 32'h0, 32'h74, 4'hF);
        mem_ready = 1'b1;
        tbRdata   = 32'h3333;
        tick();
        mem_ready = 1'b0;
        #3;
        chk("rst2nd.pre.req", {31'h0, mem_req}, 32'h1);
        chk("rst2nd.pre.addr", mem_addr, 32'h504);
        chk("rst2nd.pre.stall", {31'h0, mem_stall}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst2nd.req", {31'h0, mem_req}, 32'h0);
        chk("rst2nd.stall", {31'h0, mem_stall}, 32'h0);
        chk("rst2nd.rdata1", rdata1, 32'h0);
        rst = 1'b0;
        clearLanes();
        tick();
        setLane1(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h80, 4'hF);
        mem_ready = 1'b1;
        tbRdata   = 32'h4242;
        #3;
        chk("rst2nd.next.req", {31'h0, mem_req}, 32'h1);
        chk("rst2nd.next.addr", mem_addr, 32'h100);
        chk("rst2nd.next.stall", {31'h0, mem_stall}, 32'h0);
        chk("rst2nd.next.rdata1", rdata1, 32'h4242);
        tick();
        clearLanes();

`ifdef DMEM_ARB_PERF_EN
        // Four back-to-back conflicts, each served in two ready cycles
        pulseReset();
        setLane1(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h10, 4'hF);
        setLane2(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h14, 4'hF);
        mem_ready = 1'b1;
        repeat (8) tick();
        clearLanes();
        #3;
        chk("perf.conflict", perfConflictCnt, 32'd4);
        chk("perf.stall", perfStallCnt, 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
